piso_serializer: RTL and testbench

- Parallel-in, serial-out stage that sits directly upstream of the team's 4-bit serial-in shift register.
- Accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock on sdata, which connects straight to the shift register's serial input.
- Bit order is chosen so that after WIDTH clocks the downstream register's parallel output equals the accepted word.
- A one-word holding buffer allows back-to-back words to stream with no idle bit between them.

---
 rtl/piso_serializer_pkg.sv | 8 +
 rtl/piso_serializer_if.sv | 13 +
 rtl/piso_serializer_shifter.sv | 21 ++
 rtl/piso_serializer.sv | 79 +++++++
 tb/tb_piso_serializer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared types and helpers for the serializer slice
package serial_pkg;
   localparam int SER_WIDTH_DEFAULT = 4;
   typedef enum logic {IDLE, SHIFT} ser_state_t;
   function automatic int ser_cnt_w(input int width);
      return $clog2(width);
   endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake in, serial bit stream out
interface piso_serializer_if #(parameter int WIDTH = serial_pkg::SER_WIDTH_DEFAULT);
   logic [WIDTH-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic sdata;
   logic svalid;
   logic sfirst;
   logic slast;
   logic busy;
   modport master (output in_data, in_valid, input in_ready, sdata, svalid, sfirst, slast, busy);
   modport slave (input in_data, in_valid, output in_ready, sdata, svalid, sfirst, slast, busy);
endinterface

// File: rtl/piso_serializer_shifter.sv
// piso_shifter: parallel-load shift register, zero fill, selectable bit order
module piso_shifter #(
   parameter int WIDTH = 4,
   parameter bit MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   output logic             bit_out
);
   logic [WIDTH-1:0] sr;
   // load wins over shift so a reload on the last bit starts the next word cleanly
   always_ff @(posedge clk) begin
      if (reset) sr <= '0;
      else if (load) sr <= load_data;
      else if (shift) sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
   end
   assign bit_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: handshake-fed serializer with one-word holding buffer
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEFAULT,
   parameter bit MSB_FIRST = 1
) (
   input logic clk,
   input logic reset,
   piso_serializer_if.slave s
);
   localparam int CW = ser_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   ser_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic buf_full, buf_full_n;
   logic [WIDTH-1:0] buf_data, buf_data_n, load_data;
   logic load, shift, bit_out, fire, at_end, live;
   assign fire = s.in_valid & s.in_ready;
   assign at_end = cnt == LAST;
   // next state: start on transfer, reload from buffer or input at word end, else buffer early words
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      buf_full_n = buf_full;
      buf_data_n = buf_data;
      load = 1'b0;
      load_data = s.in_data;
      shift = 1'b0;
      if (state == IDLE) begin
         if (fire) begin
            load = 1'b1;
            cnt_n = '0;
            state_n = SHIFT;
         end
      end else begin
         shift = 1'b1;
         if (at_end) begin
            cnt_n = '0;
            if (buf_full) begin
               load = 1'b1;
               load_data = buf_data;
               buf_full_n = 1'b0;
            end else if (fire) load = 1'b1;
            else state_n = IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
            if (fire) begin
               buf_full_n = 1'b1;
               buf_data_n = s.in_data;
            end
         end
      end
   end
   // state, bit counter and holding buffer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         buf_full <= 1'b0;
         buf_data <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         buf_full <= buf_full_n;
         buf_data <= buf_data_n;
      end
   end
   piso_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
      .clk(clk), .reset(reset), .load(load), .load_data(load_data), .shift(shift), .bit_out(bit_out)
   );
   assign live = (state == SHIFT) & ~reset;
   assign s.svalid = live;
   assign s.sdata = live & bit_out;
   assign s.sfirst = live & (cnt == '0);
   assign s.slast = live & at_end;
   assign s.busy = ((state == SHIFT) | buf_full) & ~reset;
   assign s.in_ready = ~buf_full & ~reset;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector table, hand sequences and scoreboarded random stress
module tb_piso_serializer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;

   piso_serializer_if #(4) a_if ();
   piso_serializer_if #(4) b_if ();
   piso_serializer_if #(8) c_if ();
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_a (.clk(clk), .reset(reset), .s(a_if));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_b (.clk(clk), .reset(reset), .s(b_if));
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_c (.clk(clk), .reset(reset), .s(c_if));

   // downstream 4-bit serial-in shift register fed by dut_a
   logic [3:0] dout = 4'h0;
   always @(posedge clk) dout <= {dout[2:0], a_if.sdata};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // scoreboards: words pushed on transfer, popped when a word completes on the serial side
   logic [15:0] qa[$], qc[$];
   logic [15:0] acc_a = 0, acc_c = 0;
   int na = 0, nc = 0, acc_cnt_c = 0, recv_c = 0;
   always @(negedge clk) begin
      if (reset) begin
         qa.delete();
         na = 0;
      end else begin
         if (a_if.in_valid & a_if.in_ready) qa.push_back(16'(a_if.in_data));
         if (a_if.svalid) begin
            if (a_if.sfirst) begin acc_a = 0; na = 0; end
            acc_a = {acc_a[14:0], a_if.sdata};
            na++;
            if (a_if.slast) begin
               chk("a_len", na, 4);
               if (qa.size() == 0) chk("a_unexpected_word", 1, 0);
               else chk("a_word", 32'(acc_a[3:0]), 32'(qa.pop_front()));
            end
         end
      end
   end
   always @(negedge clk) begin
      if (reset) begin
         qc.delete();
         nc = 0;
      end else begin
         if (c_if.in_valid & c_if.in_ready) begin
            qc.push_back(16'(c_if.in_data));
            acc_cnt_c++;
         end
         if (c_if.svalid) begin
            if (c_if.sfirst) begin acc_c = 0; nc = 0; end
            acc_c = {acc_c[14:0], c_if.sdata};
            nc++;
            if (c_if.slast) begin
               recv_c++;
               chk("c_len", nc, 8);
               if (qc.size() == 0) chk("c_unexpected_word", 1, 0);
               else chk("c_word", 32'(acc_c[7:0]), 32'(qc.pop_front()));
            end
         end
      end
   end

   typedef struct {
      logic v;
      logic [3:0] d;
      logic [5:0] exp;
      logic dchk;
      logic [3:0] dexp;
   } vec_t;
   vec_t tv[$];

   function automatic vec_t r(logic v, logic [3:0] d, logic [5:0] e, logic dc = 1'b0, logic [3:0] de = 4'h0);
      vec_t x;
      x.v = v; x.d = d; x.exp = e; x.dchk = dc; x.dexp = de;
      return x;
   endfunction

   function automatic logic [5:0] outs_a();
      return {a_if.in_ready, a_if.sdata, a_if.svalid, a_if.sfirst, a_if.slast, a_if.busy};
   endfunction

   initial begin
      logic [3:0] bw;
      a_if.in_valid = 0; a_if.in_data = 0;
      b_if.in_valid = 0; b_if.in_data = 0;
      c_if.in_valid = 0; c_if.in_data = 0;
      // exp = {in_ready, sdata, svalid, sfirst, slast, busy}
      for (int i = 0; i < 5; i++) tv.push_back(r(0, 4'h0, 6'b100000));
      tv.push_back(r(1, 4'b1011, 6'b100000));
      tv.push_back(r(0, 4'h0, 6'b111101));
      tv.push_back(r(0, 4'h0, 6'b101001));
      tv.push_back(r(0, 4'h0, 6'b111001));
      tv.push_back(r(0, 4'h0, 6'b111011));
      tv.push_back(r(0, 4'h0, 6'b100000, 1, 4'b1011));
      tv.push_back(r(1, 4'hA, 6'b100000));
      tv.push_back(r(1, 4'h5, 6'b111101));
      tv.push_back(r(0, 4'h0, 6'b001001));
      tv.push_back(r(0, 4'h0, 6'b011001));
      tv.push_back(r(0, 4'h0, 6'b001011));
      tv.push_back(r(0, 4'h0, 6'b101101, 1, 4'hA));
      tv.push_back(r(0, 4'h0, 6'b111001));
      tv.push_back(r(0, 4'h0, 6'b101001));
      tv.push_back(r(0, 4'h0, 6'b111011));
      tv.push_back(r(0, 4'h0, 6'b100000, 1, 4'h5));
      tv.push_back(r(1, 4'hC, 6'b100000));
      tv.push_back(r(0, 4'h0, 6'b111101));
      tv.push_back(r(0, 4'h0, 6'b111001));
      tv.push_back(r(0, 4'h0, 6'b101001));
      tv.push_back(r(1, 4'h3, 6'b101011));
      tv.push_back(r(0, 4'h0, 6'b101101, 1, 4'hC));
      tv.push_back(r(0, 4'h0, 6'b101001));
      tv.push_back(r(0, 4'h0, 6'b111001));
      tv.push_back(r(0, 4'h0, 6'b111011));
      tv.push_back(r(0, 4'h0, 6'b100000, 1, 4'h3));

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs_a", 32'(outs_a()), 0);
      chk("rst_outs_c", 32'({c_if.in_ready, c_if.svalid, c_if.busy}), 0);
      reset = 0;

      foreach (tv[i]) begin
         @(posedge clk); #1;
         a_if.in_valid = tv[i].v;
         a_if.in_data = tv[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'(outs_a()), 32'(tv[i].exp));
         if (tv[i].dchk) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tv[i].dexp));
      end

      bw = 4'b0001;
      @(posedge clk); #1;
      b_if.in_valid = 1; b_if.in_data = bw;
      @(posedge clk); #1;
      b_if.in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("lsb_bit%0d", i), 32'({b_if.svalid, b_if.sdata, b_if.sfirst}), 32'({1'b1, bw[i], i == 0}));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("lsb_idle", 32'({b_if.svalid, b_if.busy, b_if.in_ready}), 32'(3'b001));

      @(posedge clk); #1;
      a_if.in_valid = 1; a_if.in_data = 4'hF;
      @(posedge clk); #1;
      a_if.in_valid = 0;
      @(negedge clk);
      chk("mid_first_bit", 32'({a_if.svalid, a_if.sfirst}), 32'(2'b11));
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      chk("mid_during_rst", 32'(outs_a()), 0);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("mid_after_rst", 32'(outs_a()), 32'(6'b100000));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("mid_quiet%0d", i), 32'(a_if.svalid), 0);
      end

      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         c_if.in_valid = ($urandom_range(0, 3) != 0);
         c_if.in_data = 8'($urandom);
      end
      @(posedge clk); #1;
      c_if.in_valid = 0;
      for (int k = 0; k < 100 && (qc.size() != 0 || c_if.busy); k++) @(posedge clk);
      @(negedge clk);
      chk("c_drained", qc.size(), 0);
      chk("c_count", recv_c, acc_cnt_c);
      chk("c_enough", 32'(recv_c > 40), 1);
      chk("a_drained", qa.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
